// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch unit with an internal word-addressed
// instruction memory, a FIFO_DEPTH-entry prefetch queue and a valid/ready
// output carrying each instruction together with its word address.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   redir, pc_sel       redirect pulse; pc_sel 01 alu_addr, 10 imm_addr,
//                       11 RESET_PC, 00 ignores redir
//   alu_addr, imm_addr  redirect targets
//   instr, instr_pc     queue head (zero when instr_valid=0)
//   instr_valid/ready   output handshake
//   fetch_pc            next address to be issued
//   cntlr_wr/waddr/wr_data   loader write port (highest priority)
//   cntlr_rd/raddr           loader read port
//   cntlr_rd_data/rd_valid   read result, valid pulses one cycle later
module ifetch_queue #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redir,
    input  logic [1:0]            pc_sel,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    input  logic [ADDR_WIDTH-1:0] imm_addr,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [ADDR_WIDTH-1:0] fetch_pc,
    input  logic                  cntlr_wr,
    input  logic [ADDR_WIDTH-1:0] cntlr_waddr,
    input  logic [DATA_WIDTH-1:0] cntlr_wr_data,
    input  logic                  cntlr_rd,
    input  logic [ADDR_WIDTH-1:0] cntlr_raddr,
    output logic [DATA_WIDTH-1:0] cntlr_rd_data,
    output logic                  cntlr_rd_valid
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    entry_t                fifo_q [FIFO_DEPTH];

    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] infl_pc_q;
    logic                  infl_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_hold_q;

    logic                  redir_act, rd_acc, credit_ok, issue, push, pop;
    logic [ADDR_WIDTH-1:0] target, mem_raddr;

    always_comb begin
        redir_act = redir && (pc_sel != 2'b00);
        rd_acc    = cntlr_rd && !cntlr_wr && !rst;
        // In-flight reads hold a slot so a full queue never drops a word.
        credit_ok = (count_q + CW'(infl_q)) < CW'(FIFO_DEPTH);
        issue     = !rst && !cntlr_wr && !cntlr_rd && !redir_act && credit_ok;
        // A redirect or reset in the cycle the data arrives discards it.
        push      = infl_q && !redir_act && !rst;
        pop       = instr_valid && instr_ready;
        case (pc_sel)
            2'b01:   target = alu_addr;
            2'b10:   target = imm_addr;
            default: target = RESET_PC;
        endcase
        mem_raddr = cntlr_rd ? cntlr_raddr : fetch_pc_q;
        if (redir_act)  fetch_pc_d = target;
        else if (issue) fetch_pc_d = fetch_pc_q + 1'b1;
        else            fetch_pc_d = fetch_pc_q;
    end

    // Single-port memory: one write or one read per cycle, never reset.
    always_ff @(posedge clk) begin
        if (cntlr_wr)
            mem[cntlr_waddr] <= cntlr_wr_data;
        else if (rd_acc || issue)
            rdata_q <= mem[mem_raddr];
    end

    // Queue storage carries no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_ptr_q] <= '{pc: infl_pc_q, data: rdata_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            infl_q     <= 1'b0;
            infl_pc_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_hold_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            infl_q     <= issue;
            if (issue)
                infl_pc_q <= fetch_pc_q;
            rd_valid_q <= rd_acc;
            // rdata_q is reused by fetch, so keep a copy of the last read.
            if (rd_valid_q)
                rd_hold_q <= rdata_q;
            if (redir_act) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    always_comb begin
        instr_valid    = (count_q != '0);
        instr          = instr_valid ? fifo_q[rd_ptr_q].data : '0;
        instr_pc       = instr_valid ? fifo_q[rd_ptr_q].pc : '0;
        fetch_pc       = fetch_pc_q;
        cntlr_rd_valid = rd_valid_q;
        cntlr_rd_data  = rd_valid_q ? rdata_q : rd_hold_q;
    end

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst, redir, instr_ready, cntlr_wr, cntlr_rd;
    logic [1:0]    pc_sel;
    logic [AW-1:0] alu_addr, imm_addr, cntlr_waddr, cntlr_raddr;
    logic [DW-1:0] cntlr_wr_data;
    logic [DW-1:0] instr, cntlr_rd_data;
    logic [AW-1:0] instr_pc, fetch_pc;
    logic          instr_valid, cntlr_rd_valid;

    ifetch_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(D), .RESET_PC('0)) dut (
        .clk(clk), .rst(rst), .redir(redir), .pc_sel(pc_sel),
        .alu_addr(alu_addr), .imm_addr(imm_addr),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .fetch_pc(fetch_pc),
        .cntlr_wr(cntlr_wr), .cntlr_waddr(cntlr_waddr), .cntlr_wr_data(cntlr_wr_data),
        .cntlr_rd(cntlr_rd), .cntlr_raddr(cntlr_raddr),
        .cntlr_rd_data(cntlr_rd_data), .cntlr_rd_valid(cntlr_rd_valid)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            failures = 0;
    int            delivered = 0;
    logic [DW-1:0] m [2**AW];      // reference memory image
    logic          mon_en = 1'b0;
    logic          mon_rd_en = 1'b0;
    logic [AW-1:0] exp_pc = '0;    // next pc the consumer must see

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model of the delivered stream and the controller read port.
    task automatic monitor();
        logic          exp_rd_v = 1'b0;
        logic [DW-1:0] exp_rd_d = '0;
        logic          hold_v = 1'b0;
        logic [DW-1:0] hold_i = '0;
        logic [AW-1:0] hold_pc = '0;
        logic [AW-1:0] tgt;
        forever begin
            @(negedge clk);
            if (mon_rd_en) begin
                checks++;
                if (cntlr_rd_valid !== exp_rd_v) begin
                    failures++;
                    $display("FAIL mon_rd_valid got=%0b exp=%0b t=%0t", cntlr_rd_valid, exp_rd_v, $time);
                end
                if (exp_rd_v) begin
                    checks++;
                    if (cntlr_rd_data !== exp_rd_d) begin
                        failures++;
                        $display("FAIL mon_rd_data got=%h exp=%h t=%0t", cntlr_rd_data, exp_rd_d, $time);
                    end
                end
            end
            exp_rd_v = cntlr_rd && !cntlr_wr && !rst;
            exp_rd_d = m[cntlr_raddr];
            if (mon_en) begin
                if (hold_v) begin
                    checks++;
                    if (!instr_valid || instr !== hold_i || instr_pc !== hold_pc) begin
                        failures++;
                        $display("FAIL mon_stable got=%0b/%h/%0d exp=1/%h/%0d t=%0t",
                                 instr_valid, instr, instr_pc, hold_i, hold_pc, $time);
                    end
                end
                if (instr_valid && instr_ready) begin
                    checks++;
                    if (instr_pc !== exp_pc || instr !== m[exp_pc]) begin
                        failures++;
                        $display("FAIL mon_stream got=%0d/%h exp=%0d/%h t=%0t",
                                 instr_pc, instr, exp_pc, m[exp_pc], $time);
                    end
                    exp_pc++;
                    delivered++;
                end else if (!instr_valid) begin
                    checks++;
                    if (instr !== '0 || instr_pc !== '0) begin
                        failures++;
                        $display("FAIL mon_idle_zero got=%h/%0d exp=0/0 t=%0t", instr, instr_pc, $time);
                    end
                end
                hold_v  = instr_valid && !instr_ready && !rst && !(redir && pc_sel != 2'b00);
                hold_i  = instr;
                hold_pc = instr_pc;
                case (pc_sel)
                    2'b01:   tgt = alu_addr;
                    2'b10:   tgt = imm_addr;
                    default: tgt = '0;
                endcase
                if (rst) exp_pc = '0;
                else if (redir && pc_sel != 2'b00) exp_pc = tgt;
            end else begin
                hold_v = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) cyc();
        checks += 6;
        if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", instr_valid); end
        if (instr !== '0) begin failures++; $display("FAIL reset_instr got=%h exp=0", instr); end
        if (instr_pc !== '0) begin failures++; $display("FAIL reset_instr_pc got=%0d exp=0", instr_pc); end
        if (fetch_pc !== '0) begin failures++; $display("FAIL reset_fetch_pc got=%0d exp=0", fetch_pc); end
        if (cntlr_rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%0b exp=0", cntlr_rd_valid); end
        if (cntlr_rd_data !== '0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", cntlr_rd_data); end
        mon_rd_en = 1'b1;
    endtask

    task automatic test_load();
        rst = 1'b0;
        for (int i = 0; i < 2**AW; i++) begin
            cntlr_wr = 1'b1; cntlr_waddr = AW'(i); cntlr_wr_data = DW'(i); m[i] = DW'(i);
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            cntlr_wr = 1'b1; cntlr_waddr = AW'(5 + i); cntlr_wr_data = 32'hA5A50001 + DW'(i);
            m[5 + i] = 32'hA5A50001 + DW'(i);
            cyc();
        end
        cntlr_wr = 1'b0; cntlr_rd = 1'b1; cntlr_raddr = 6;
        cyc();
        cntlr_rd = 1'b0;
        checks++;
        if (cntlr_rd_valid !== 1'b1 || cntlr_rd_data !== 32'hA5A50002) begin
            failures++; $display("FAIL load_readback got=%0b/%h exp=1/a5a50002", cntlr_rd_valid, cntlr_rd_data);
        end
        cyc();
        checks++;
        if (cntlr_rd_valid !== 1'b0 || cntlr_rd_data !== 32'hA5A50002) begin
            failures++; $display("FAIL load_hold got=%0b/%h exp=0/a5a50002", cntlr_rd_valid, cntlr_rd_data);
        end
        // write and read together: write wins, read is dropped
        cntlr_wr = 1'b1; cntlr_waddr = 100; cntlr_wr_data = 32'h5A5A0100; m[100] = 32'h5A5A0100;
        cntlr_rd = 1'b1; cntlr_raddr = 6;
        cyc();
        cntlr_wr = 1'b0;
        checks++;
        if (cntlr_rd_valid !== 1'b0) begin failures++; $display("FAIL load_wr_rd_drop got=%0b exp=0", cntlr_rd_valid); end
        cntlr_raddr = 100;
        cyc();
        cntlr_rd = 1'b0;
        checks++;
        if (cntlr_rd_valid !== 1'b1 || cntlr_rd_data !== 32'h5A5A0100) begin
            failures++; $display("FAIL load_raw got=%0b/%h exp=1/5a5a0100", cntlr_rd_valid, cntlr_rd_data);
        end
    endtask

    task automatic test_stream();
        rst = 1'b1;
        cyc();
        rst = 1'b0; instr_ready = 1'b1; exp_pc = '0; mon_en = 1'b1;
        checks += 2;
        if (instr_valid !== 1'b0) begin failures++; $display("FAIL stream_r_valid got=%0b exp=0", instr_valid); end
        if (fetch_pc !== '0) begin failures++; $display("FAIL stream_r_fetch_pc got=%0d exp=0", fetch_pc); end
        cyc();
        checks++;
        if (instr_valid !== 1'b0) begin failures++; $display("FAIL stream_r1_valid got=%0b exp=0", instr_valid); end
        cyc();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== '0 || instr !== '0) begin
            failures++; $display("FAIL stream_r2_first got=%0b/%0d/%h exp=1/0/0", instr_valid, instr_pc, instr);
        end
        for (int k = 0; k < 20; k++) begin
            cyc();
            checks++;
            if (instr_valid !== 1'b1) begin failures++; $display("FAIL stream_rate k=%0d got=0 exp=1", k); end
        end
        // jump near the top of memory and watch the address wrap
        redir = 1'b1; pc_sel = 2'b10; imm_addr = 2044;
        cyc();
        redir = 1'b0; pc_sel = 2'b00;
        repeat (2) cyc();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 11'd2044) begin
            failures++; $display("FAIL stream_wrap_tgt got=%0b/%0d exp=1/2044", instr_valid, instr_pc);
        end
        repeat (6) cyc();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 11'd2 || instr !== 32'd2) begin
            failures++; $display("FAIL stream_wrap got=%0b/%0d/%h exp=1/2/2", instr_valid, instr_pc, instr);
        end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] h, diff;
        instr_ready = 1'b0;
        h = instr_pc;
        for (int k = 0; k < 10; k++) begin
            cyc();
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== h) begin
                failures++; $display("FAIL bp_head k=%0d got=%0b/%0d exp=1/%0d", k, instr_valid, instr_pc, h);
            end
        end
        diff = fetch_pc - instr_pc;
        checks++;
        if (diff !== AW'(D)) begin failures++; $display("FAIL bp_occupancy got=%0d exp=%0d", diff, D); end
        instr_ready = 1'b1;
        repeat (12) cyc();
    endtask

    task automatic test_redirect();
        logic [1:0]    sels [3] = '{2'b10, 2'b01, 2'b11};
        logic [AW-1:0] tgts [3] = '{11'd6, 11'd7, 11'd0};
        logic [AW-1:0] p;
        for (int k = 0; k < 3; k++) begin
            redir = 1'b1; pc_sel = sels[k];
            imm_addr = (k == 1) ? 11'd9 : 11'd6;
            alu_addr = (k == 0) ? 11'd9 : 11'd7;
            cyc();
            redir = 1'b0; pc_sel = 2'b00;
            checks++;
            if (instr_valid !== 1'b0) begin failures++; $display("FAIL redir_flush sel=%0d got=1 exp=0", sels[k]); end
            cyc();
            checks++;
            if (instr_valid !== 1'b0) begin failures++; $display("FAIL redir_t2 sel=%0d got=1 exp=0", sels[k]); end
            cyc();
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== tgts[k] || instr !== m[tgts[k]]) begin
                failures++; $display("FAIL redir_t3 sel=%0d got=%0b/%0d/%h exp=1/%0d/%h",
                                     sels[k], instr_valid, instr_pc, instr, tgts[k], m[tgts[k]]);
            end
            repeat (5) cyc();
        end
        // pc_sel=00 makes redir a no-op
        p = instr_pc;
        redir = 1'b1; pc_sel = 2'b00; imm_addr = 11'd6;
        cyc();
        redir = 1'b0;
        repeat (3) cyc();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== p + 11'd4) begin
            failures++; $display("FAIL redir_none got=%0b/%0d exp=1/%0d", instr_valid, instr_pc, p + 11'd4);
        end
    endtask

    task automatic test_contention();
        logic [AW-1:0] fp, tgt;
        logic [DW-1:0] nd;
        logic          found;
        fp = fetch_pc;
        cntlr_rd = 1'b1; cntlr_raddr = 7;
        cyc();
        cntlr_rd = 1'b0;
        checks += 2;
        if (fetch_pc !== fp) begin failures++; $display("FAIL cont_rd_stall got=%0d exp=%0d", fetch_pc, fp); end
        if (cntlr_rd_valid !== 1'b1 || cntlr_rd_data !== 32'hA5A50003) begin
            failures++; $display("FAIL cont_rd_data got=%0b/%h exp=1/a5a50003", cntlr_rd_valid, cntlr_rd_data);
        end
        cyc();
        checks++;
        if (fetch_pc !== fp + 11'd1) begin failures++; $display("FAIL cont_resume got=%0d exp=%0d", fetch_pc, fp + 11'd1); end
        repeat (4) cyc();
        // overwrite a word that has not been fetched yet
        fp = fetch_pc; tgt = fp + 11'd6; nd = 32'hC0DE0000 | DW'(tgt);
        cntlr_wr = 1'b1; cntlr_waddr = tgt; cntlr_wr_data = nd; m[tgt] = nd;
        cyc();
        cntlr_wr = 1'b0;
        checks++;
        if (fetch_pc !== fp) begin failures++; $display("FAIL cont_wr_stall got=%0d exp=%0d", fetch_pc, fp); end
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (instr_valid && instr_ready && instr_pc == tgt) begin
                found = 1'b1;
                checks++;
                if (instr !== nd) begin failures++; $display("FAIL cont_new_data got=%h exp=%h", instr, nd); end
            end
            cyc();
        end
        if (!found) begin
            checks++; failures++;
            $display("FAIL cont_new_data_timeout got=none exp=pc %0d", tgt);
        end
        repeat (4) cyc();
    endtask

    task automatic test_reset_mid();
        instr_ready = 1'b0;
        repeat (2) cyc();
        checks++;
        if (instr_valid !== 1'b1) begin failures++; $display("FAIL rmid_queued got=0 exp=1"); end
        rst = 1'b1; cntlr_rd = 1'b1; cntlr_raddr = 6;
        cyc();
        rst = 1'b0; cntlr_rd = 1'b0; instr_ready = 1'b1;
        checks += 4;
        if (instr_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=1 exp=0"); end
        if (fetch_pc !== '0) begin failures++; $display("FAIL rmid_fetch_pc got=%0d exp=0", fetch_pc); end
        if (cntlr_rd_valid !== 1'b0) begin failures++; $display("FAIL rmid_rd_drop got=1 exp=0"); end
        if (cntlr_rd_data !== '0) begin failures++; $display("FAIL rmid_rd_data got=%h exp=0", cntlr_rd_data); end
        cntlr_rd = 1'b1; cntlr_raddr = 6;
        cyc();
        cntlr_rd = 1'b0;
        checks++;
        if (cntlr_rd_valid !== 1'b1 || cntlr_rd_data !== 32'hA5A50002) begin
            failures++; $display("FAIL rmid_mem_kept got=%0b/%h exp=1/a5a50002", cntlr_rd_valid, cntlr_rd_data);
        end
        repeat (6) cyc();
    endtask

    task automatic test_random();
        int d0;
        d0 = delivered;
        for (int k = 0; k < 3000; k++) begin
            instr_ready = ($urandom % 10) < 7;
            cntlr_rd    = ($urandom % 25) == 0;
            cntlr_raddr = AW'($urandom);
            redir       = ($urandom % 40) == 0;
            pc_sel      = 2'($urandom);
            alu_addr    = AW'($urandom);
            imm_addr    = AW'($urandom);
            rst         = ($urandom % 400) == 0;
            cyc();
        end
        instr_ready = 1'b1; cntlr_rd = 1'b0; redir = 1'b0; pc_sel = 2'b00; rst = 1'b0;
        repeat (10) cyc();
        checks++;
        if (delivered - d0 < 1000) begin
            failures++; $display("FAIL rand_progress got=%0d exp>=1000", delivered - d0);
        end
    endtask

    initial begin
        rst = 1'b1; redir = 1'b0; pc_sel = 2'b00; alu_addr = '0; imm_addr = '0;
        instr_ready = 1'b0; cntlr_wr = 1'b0; cntlr_waddr = '0; cntlr_wr_data = '0;
        cntlr_rd = 1'b0; cntlr_raddr = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_load();
        test_stream();
        test_backpressure();
        test_redirect();
        test_contention();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
